filter_stream_scheduler: RTL



---
 rtl/filter_sched_pkg.sv | 17 +
 rtl/stream_delay.sv | 47 ++++
 rtl/filter_stream_scheduler.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/filter_sched_pkg.sv
// Shared types and helpers for the filter stream scheduler.
package filter_sched_pkg;

   localparam int PIX_W       = 16;
   localparam int MODE_BYPASS = 0;

   typedef logic [PIX_W-1:0] pix_t;

   // Wrap-around mode step: up=1 -> next mode, up=0 -> previous mode.
   function automatic int mode_wrap(input int base, input logic up, input int num_modes);
      if (up)
         return (base >= num_modes - 1) ? 0 : base + 1;
      else
         return (base == 0) ? num_modes - 1 : base - 1;
   endfunction

endpackage

// File: rtl/stream_delay.sv
// Delay line that lines the raw pixel stream up with the filter outputs.
// Only the write-enable bits are reset; address/data are don't-care while we=0.
module stream_delay
   import filter_sched_pkg::*;
#(
   parameter int LAT = 1,
   parameter int AW  = 17
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          src_we,
   input  logic [AW-1:0] src_addr,
   input  pix_t          src_data,
   output logic          dly_we,
   output logic [AW-1:0] dly_addr,
   output pix_t          dly_data
);

   logic [LAT-1:0] we_sr;
   logic [AW-1:0]  addr_sr [LAT];
   pix_t           data_sr [LAT];

   // Write-enable shift register, cleared on reset so no stale beat emerges.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we_sr <= '0;
      end else begin
         we_sr[0] <= src_we;
         for (int i = 1; i < LAT; i++) we_sr[i] <= we_sr[i-1];
      end
   end

   // Address/data shift register, no reset needed.
   always_ff @(posedge clk) begin
      addr_sr[0] <= src_addr;
      data_sr[0] <= src_data;
      for (int i = 1; i < LAT; i++) begin
         addr_sr[i] <= addr_sr[i-1];
         data_sr[i] <= data_sr[i-1];
      end
   end

   assign dly_we   = we_sr[LAT-1];
   assign dly_addr = addr_sr[LAT-1];
   assign dly_data = data_sr[LAT-1];

endmodule

// File: rtl/filter_stream_scheduler.sv
// Chooses bypass or one filter stream for the frame-buffer write port and
// switches only on frame boundaries (aligned beat with we=1, addr=0).
// Optional FB_FREEZE_EN: freeze_req sampled at each boundary suppresses
// frame-buffer writes and frame_done for that whole frame.
module filter_stream_scheduler
   import filter_sched_pkg::*;
#(
   parameter int  IMG_WIDTH   = 320,
   parameter int  IMG_HEIGHT  = 240,
   parameter int  NUM_FILTERS = 2,
   parameter int  FILTER_LAT  = 1,
   localparam int AW          = $clog2(IMG_WIDTH*IMG_HEIGHT),
   localparam int NUM_MODES   = NUM_FILTERS + 1,
   localparam int MW          = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      we_in,
   input  logic [AW-1:0]             wAddr_in,
   input  pix_t                      wData_in,
   input  logic [NUM_FILTERS-1:0]    flt_we,
   input  logic [NUM_FILTERS*AW-1:0] flt_addr,
   input  logic [NUM_FILTERS*16-1:0] flt_data,
   input  logic                      btn_next,
   input  logic                      btn_prev,
   input  logic                      sel_valid,
   input  logic [MW-1:0]             sel_mode,
   input  logic                      freeze_req,
   output logic                      fb_we,
   output logic [AW-1:0]             fb_addr,
   output pix_t                      fb_data,
   output logic [MW-1:0]             mode_cur,
   output logic                      mode_pend_valid,
   output logic                      frame_done,
   output logic                      frozen
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_WIDTH*IMG_HEIGHT - 1);

   logic          al_we;
   logic [AW-1:0] al_addr;
   pix_t          al_data;
   logic          boundary;
   logic [MW-1:0] pend_mode;
   logic [MW-1:0] mode_eff;
   logic [MW-1:0] base;
   logic [MW-1:0] req_mode;
   logic          req_valid;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   pix_t          sel_data;
   logic          freeze_eff;

   stream_delay #(
      .LAT (FILTER_LAT),
      .AW  (AW)
   ) u_delay (
      .clk      (clk),
      .reset    (reset),
      .src_we   (we_in),
      .src_addr (wAddr_in),
      .src_data (wData_in),
      .dly_we   (al_we),
      .dly_addr (al_addr),
      .dly_data (al_data)
   );

   assign boundary = al_we && (al_addr == '0);
   // The boundary beat itself already uses the newly applied mode.
   assign mode_eff = (boundary && mode_pend_valid) ? pend_mode : mode_cur;
   assign base     = mode_pend_valid ? pend_mode : mode_cur;

   // Request decode: direct select wins, then next, then prev; conflicts dropped.
   always_comb begin
      req_valid = 1'b0;
      req_mode  = base;
      if (sel_valid) begin
         if ({1'b0, sel_mode} < (MW+1)'(NUM_MODES)) begin
            req_valid = 1'b1;
            req_mode  = sel_mode;
         end
      end else if (btn_next && !btn_prev) begin
         req_valid = 1'b1;
         req_mode  = MW'(mode_wrap(int'(base), 1'b1, NUM_MODES));
      end else if (btn_prev && !btn_next) begin
         req_valid = 1'b1;
         req_mode  = MW'(mode_wrap(int'(base), 1'b0, NUM_MODES));
      end
   end

   // Active/pending mode registers; a request on a boundary cycle queues for the next one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_cur        <= MW'(MODE_BYPASS);
         pend_mode       <= MW'(MODE_BYPASS);
         mode_pend_valid <= 1'b0;
      end else begin
         if (boundary && mode_pend_valid) begin
            mode_cur        <= pend_mode;
            mode_pend_valid <= 1'b0;
         end
         if (req_valid) begin
            pend_mode       <= req_mode;
            mode_pend_valid <= 1'b1;
         end
      end
   end

   // Stream mux: bypass uses the aligned raw beat, filter k uses its own port.
   always_comb begin
      sel_we   = al_we;
      sel_addr = al_addr;
      sel_data = al_data;
      for (int k = 0; k < NUM_FILTERS; k++) begin
         if (mode_eff == MW'(k + 1)) begin
            sel_we   = flt_we[k];
            sel_addr = flt_addr[k*AW +: AW];
            sel_data = flt_data[k*16 +: 16];
         end
      end
   end

`ifdef FB_FREEZE_EN
   assign freeze_eff = boundary ? freeze_req : frozen;

   // Freeze state is latched per frame at the boundary beat.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) frozen <= 1'b0;
      else       frozen <= freeze_eff;
   end
`else
   logic unused_freeze_req;
   assign unused_freeze_req = freeze_req;
   assign freeze_eff        = 1'b0;
   assign frozen            = 1'b0;
`endif

   // Registered frame-buffer write port; address/data keep updating while frozen.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fb_we   <= 1'b0;
         fb_addr <= '0;
         fb_data <= '0;
      end else begin
         fb_we   <= sel_we && !freeze_eff;
         fb_addr <= sel_addr;
         fb_data <= sel_data;
      end
   end

   assign frame_done = fb_we && (fb_addr == LAST_ADDR);

endmodule
